// File: rtl/tetris_board_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tetris_board_ctl
//  Purpose  : Playfield occupancy store and line-clear engine. Merges the four
//             squares of a locking piece into a COLS x ROWS grid, then scans
//             bottom-up for full rows, collapses them one row per cycle and
//             reports cleared-line counts. Registered row-read port for the
//             renderer.
//  Options  : LINE_CLEAR_EN - when defined, the SCAN/SHIFT engine is built;
//             when undefined, WRITE goes straight to DONE and the line
//             counters stay at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module tetris_board_ctl #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            lock,
    input  logic [4:0]      sq_1_col,
    input  logic [4:0]      sq_2_col,
    input  logic [4:0]      sq_3_col,
    input  logic [4:0]      sq_4_col,
    input  logic [4:0]      sq_1_row,
    input  logic [4:0]      sq_2_row,
    input  logic [4:0]      sq_3_row,
    input  logic [4:0]      sq_4_row,
    input  logic [4:0]      rd_row,
    output logic [COLS-1:0] rd_data,
    output logic            busy,
    output logic            done,
    output logic [2:0]      lines,
    output logic [15:0]     lines_total,
    output logic            game_over
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_WRITE = 3'd1;
    localparam logic [2:0] c_DONE  = 3'd4;
`ifdef LINE_CLEAR_EN
    localparam logic [2:0] c_SCAN  = 3'd2;
    localparam logic [2:0] c_SHIFT = 3'd3;
    localparam logic [4:0] c_LAST_ROW = 5'(ROWS - 1);
`endif

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [4:0]      r_cap_col [4];
    logic [4:0]      r_cap_row [4];
    logic [COLS-1:0] r_grid    [ROWS];
    logic [COLS-1:0] w_merged  [ROWS];
    logic [COLS-1:0] r_rd_data;
    logic            r_game_over;

`ifdef LINE_CLEAR_EN
    logic [4:0]      r_scan_row;
    logic [4:0]      r_sh_row;
    logic [2:0]      r_lines;
    logic [15:0]     r_lines_total;
    logic            w_row_full;
    logic            w_retest_full;

    // Full-row test on the row under the scan pointer
    always_comb begin
        w_row_full    = &r_grid[r_scan_row];
        // In the last shift cycle the collapsed row already holds its new
        // contents (row 0 is the one being blanked, so it cannot be full).
        w_retest_full = (r_scan_row != 5'd0) && w_row_full;
    end
`endif

    // State register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (lock) w_state_nxt = c_WRITE;
`ifdef LINE_CLEAR_EN
            c_WRITE: w_state_nxt = c_SCAN;
            c_SCAN: begin
                if (w_row_full)               w_state_nxt = c_SHIFT;
                else if (r_scan_row == 5'd0)  w_state_nxt = c_DONE;
            end
            // The final shift cycle also re-tests the collapsed row, so a
            // clear at row r costs exactly r+1 cycles on top of the scan.
            c_SHIFT: begin
                if (r_sh_row == 5'd0) begin
                    if (w_retest_full)           w_state_nxt = c_SHIFT;
                    else if (r_scan_row == 5'd0) w_state_nxt = c_DONE;
                    else                         w_state_nxt = c_SCAN;
                end
            end
`else
            c_WRITE: w_state_nxt = c_DONE;
`endif
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = (r_state != c_IDLE);
        done = (r_state == c_DONE);
    end

    // Capture the piece coordinates on an accepted lock; held while busy
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_cap_col[k] <= '0;
                r_cap_row[k] <= '0;
            end
        end else if (r_state == c_IDLE && lock) begin
            r_cap_col[0] <= sq_1_col;
            r_cap_col[1] <= sq_2_col;
            r_cap_col[2] <= sq_3_col;
            r_cap_col[3] <= sq_4_col;
            r_cap_row[0] <= sq_1_row;
            r_cap_row[1] <= sq_2_row;
            r_cap_row[2] <= sq_3_row;
            r_cap_row[3] <= sq_4_row;
        end
    end

    // Grid with the captured squares OR-ed in; off-board squares never match
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            w_merged[r] = r_grid[r];
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (r_cap_row[k] == 5'(r) && r_cap_col[k] == 5'(c))
                        w_merged[r][c] = 1'b1;
                end
            end
        end
    end

    // Grid storage: piece merge in WRITE, one-row collapse per SHIFT cycle
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) r_grid[r] <= '0;
        end else if (r_state == c_WRITE) begin
            for (int r = 0; r < ROWS; r++) r_grid[r] <= w_merged[r];
        end
`ifdef LINE_CLEAR_EN
        else if (r_state == c_SHIFT) begin
            if (r_sh_row != 5'd0) r_grid[r_sh_row] <= r_grid[r_sh_row - 5'd1];
            else                  r_grid[0]        <= '0;
        end
`endif
    end

`ifdef LINE_CLEAR_EN
    // Scan/shift pointers and line counters
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_scan_row    <= '0;
            r_sh_row      <= '0;
            r_lines       <= '0;
            r_lines_total <= '0;
        end else begin
            case (r_state)
                c_WRITE: begin
                    r_lines    <= '0;
                    r_scan_row <= c_LAST_ROW;
                end
                c_SCAN: begin
                    if (w_row_full)              r_sh_row   <= r_scan_row;
                    else if (r_scan_row != 5'd0) r_scan_row <= r_scan_row - 5'd1;
                end
                c_SHIFT: begin
                    if (r_sh_row != 5'd0) begin
                        r_sh_row <= r_sh_row - 5'd1;
                    end else begin
                        r_lines <= r_lines + 3'd1;
                        if (r_lines_total != 16'hFFFF)
                            r_lines_total <= r_lines_total + 16'd1;
                        if (w_retest_full)           r_sh_row   <= r_scan_row;
                        else if (r_scan_row != 5'd0) r_scan_row <= r_scan_row - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lines       = r_lines;
    assign lines_total = r_lines_total;
`else
    assign lines       = '0;
    assign lines_total = '0;
`endif

    // Sticky game-over: top row occupied when the lock finishes
    always_ff @(posedge pclk or posedge rst) begin
        if (rst)                                       r_game_over <= 1'b0;
        else if (r_state == c_DONE && (|r_grid[0]))    r_game_over <= 1'b1;
    end

    assign game_over = r_game_over;

    // Registered renderer read port; off-board rows read as empty
    always_ff @(posedge pclk or posedge rst) begin
        if (rst)                        r_rd_data <= '0;
        else if (32'(rd_row) < ROWS)    r_rd_data <= r_grid[rd_row];
        else                            r_rd_data <= '0;
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_tetris_board_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tetris_board_ctl
//  Purpose  : Self-checking bench for tetris_board_ctl: directed vector table,
//             hand-written corner sequences and randomized locks checked
//             against a row-list reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_board_ctl;

    localparam int COLS = 10;
    localparam int ROWS = 20;
`ifdef LINE_CLEAR_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    localparam int IGN_CYC = EN ? 3 : 1;
    localparam int RST_CYC = EN ? 10 : 1;

    logic            pclk = 1'b0;
    logic            rst;
    logic            lock;
    logic [4:0]      sq_1_col, sq_2_col, sq_3_col, sq_4_col;
    logic [4:0]      sq_1_row, sq_2_row, sq_3_row, sq_4_row;
    logic [4:0]      rd_row;
    logic [COLS-1:0] rd_data;
    logic            busy, done, game_over;
    logic [2:0]      lines;
    logic [15:0]     lines_total;

    int n_tests = 0;
    int n_fail  = 0;

    tetris_board_ctl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .pclk(pclk), .rst(rst), .lock(lock),
        .sq_1_col(sq_1_col), .sq_2_col(sq_2_col), .sq_3_col(sq_3_col), .sq_4_col(sq_4_col),
        .sq_1_row(sq_1_row), .sq_2_row(sq_2_row), .sq_3_row(sq_3_row), .sq_4_row(sq_4_row),
        .rd_row(rd_row), .rd_data(rd_data), .busy(busy), .done(done),
        .lines(lines), .lines_total(lines_total), .game_over(game_over)
    );

    always #5 pclk = ~pclk;

    // Reference model state
    bit [COLS-1:0] m_grid [ROWS];
    int            m_total;
    bit            m_go;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ROWS; i++) m_grid[i] = '0;
        m_total = 0;
        m_go    = 1'b0;
    endfunction

    // Merge the piece, then drop every full row and let the rest fall.
    // A clear costs (row position at clearing time)+1 cycles; rows already
    // removed below push a full row down by that many positions.
    function automatic void model_lock(input logic [3:0][4:0] c, input logic [3:0][4:0] r,
                                       output int lat, output int nl);
        bit [COLS-1:0] keep [$];
        for (int k = 0; k < 4; k++) begin
            if (int'(c[k]) < COLS && int'(r[k]) < ROWS)
                m_grid[int'(r[k])][int'(c[k])] = 1'b1;
        end
        nl  = 0;
        lat = EN ? 2 + ROWS : 2;
        if (EN) begin
            for (int i = ROWS - 1; i >= 0; i--) begin
                if (&m_grid[i]) begin
                    lat += i + nl + 1;
                    nl++;
                end else begin
                    keep.push_back(m_grid[i]);
                end
            end
            for (int i = ROWS - 1; i >= 0; i--) begin
                int idx = ROWS - 1 - i;
                m_grid[i] = (idx < keep.size()) ? keep[idx] : '0;
            end
        end
        m_total = (m_total + nl > 65535) ? 65535 : m_total + nl;
        if (m_grid[0] != '0) m_go = 1'b1;
    endfunction

    task automatic check_grid(input string tag, input int nrows);
        for (int i = 0; i < nrows; i++) begin
            logic [COLS-1:0] exp;
            exp = '0;
            if (i < ROWS) exp = m_grid[i];
            @(negedge pclk);
            rd_row = 5'(i);
            @(negedge pclk);
            chk($sformatf("%s_row%0d", tag, i), 32'(rd_data), 32'(exp));
        end
    endtask

    task automatic do_lock(input logic [3:0][4:0] c, input logic [3:0][4:0] r,
                           input bit inject, input string tag, output int meas);
        int  lat, nl, cyc;
        bit  seen;
        @(negedge pclk);
        sq_1_col = c[0]; sq_2_col = c[1]; sq_3_col = c[2]; sq_4_col = c[3];
        sq_1_row = r[0]; sq_2_row = r[1]; sq_3_row = r[2]; sq_4_row = r[3];
        lock = 1'b1;
        model_lock(c, r, lat, nl);
        @(posedge pclk); #1;
        lock = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
        while (cyc <= 400) begin
            if (inject && cyc == IGN_CYC) begin
                lock = 1'b1;
                sq_1_col = 5'd3; sq_2_col = 5'd4; sq_3_col = 5'd5; sq_4_col = 5'd6;
                sq_1_row = 5'd8; sq_2_row = 5'd8; sq_3_row = 5'd8; sq_4_row = 5'd8;
            end
            if (inject && cyc == IGN_CYC + 1) lock = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge pclk); #1;
            cyc++;
        end
        meas = seen ? cyc : 0;
        chk({tag, "_latency"}, 32'(meas), 32'(lat));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(posedge pclk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_lines"}, 32'(lines), 32'(nl));
        chk({tag, "_total"}, 32'(lines_total), 32'(m_total));
        chk({tag, "_game_over"}, 32'(game_over), 32'(m_go));
    endtask

    task automatic apply_reset();
        @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit              do_rst;
        logic [3:0][4:0] c;
        logic [3:0][4:0] r;
        int              chk_row;
        logic [9:0]      exp_en;
        logic [9:0]      exp_dis;
        int              lines_en;
        int              lat_en;
    } vec_t;

    vec_t tbl [4];

    // Global time guard
    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int meas, cyc, dones;
        logic [3:0][4:0] c, r;

        rst = 1'b1; lock = 1'b0; rd_row = '0;
        sq_1_col = '0; sq_2_col = '0; sq_3_col = '0; sq_4_col = '0;
        sq_1_row = '0; sq_2_row = '0; sq_3_row = '0; sq_4_row = '0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        rst = 1'b0;
        model_reset();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lines", 32'(lines), 32'd0);
        chk("rst_total", 32'(lines_total), 32'd0);
        chk("rst_go", 32'(game_over), 32'd0);
        check_grid("rst", 24);

        // Directed vectors
        tbl[0] = '{1'b0, {5'd3, 5'd2, 5'd1, 5'd0}, {5'd19, 5'd19, 5'd19, 5'd19},
                   19, 10'h00F, 10'h00F, 0, 22};
        tbl[1] = '{1'b0, {5'd7, 5'd6, 5'd5, 5'd4}, {5'd19, 5'd19, 5'd19, 5'd19},
                   19, 10'h0FF, 10'h0FF, 0, 22};
        tbl[2] = '{1'b0, {5'd9, 5'd8, 5'd9, 5'd8}, {5'd18, 5'd18, 5'd19, 5'd19},
                   19, 10'h300, 10'h3FF, 1, 42};
        tbl[3] = '{1'b1, {5'd2, 5'd1, 5'd10, 5'd0}, {5'd5, 5'd5, 5'd5, 5'd5},
                   5, 10'h007, 10'h007, 0, 22};
        for (int i = 0; i < 4; i++) begin
            logic [COLS-1:0] got;
            if (tbl[i].do_rst) apply_reset();
            do_lock(tbl[i].c, tbl[i].r, 1'b0, $sformatf("tbl%0d", i), meas);
            chk($sformatf("tbl%0d_spec_latency", i), 32'(meas), 32'(EN ? tbl[i].lat_en : 2));
            chk($sformatf("tbl%0d_spec_lines", i), 32'(lines), 32'(EN ? tbl[i].lines_en : 0));
            @(negedge pclk);
            rd_row = 5'(tbl[i].chk_row);
            @(negedge pclk);
            got = rd_data;
            chk($sformatf("tbl%0d_spec_row", i), 32'(got), 32'(EN ? tbl[i].exp_en : tbl[i].exp_dis));
            check_grid($sformatf("tbl%0d", i), 24);
        end

        // Lock raised (with new coordinates) while busy must be ignored
        c = {5'd3, 5'd2, 5'd1, 5'd0};
        r = {5'd12, 5'd12, 5'd12, 5'd12};
        do_lock(c, r, 1'b1, "ignore", meas);
        repeat (3) @(posedge pclk);
        #1;
        chk("ignore_no_restart", 32'(busy), 32'd0);
        check_grid("ignore", ROWS);

        // Top-row square sets game_over, which then stays set
        c = {5'd4, 5'd4, 5'd4, 5'd4};
        r = {5'd3, 5'd2, 5'd1, 5'd0};
        do_lock(c, r, 1'b0, "go_set", meas);
        chk("go_set_direct", 32'(game_over), 32'd1);
        c = {5'd9, 5'd8, 5'd7, 5'd6};
        r = {5'd10, 5'd10, 5'd10, 5'd10};
        do_lock(c, r, 1'b0, "go_hold", meas);
        chk("go_hold_direct", 32'(game_over), 32'd1);

        // Asynchronous reset in the middle of a lock
        @(negedge pclk);
        sq_1_col = 5'd0; sq_2_col = 5'd1; sq_3_col = 5'd2; sq_4_col = 5'd3;
        sq_1_row = 5'd19; sq_2_row = 5'd19; sq_3_row = 5'd19; sq_4_row = 5'd19;
        lock = 1'b1;
        @(posedge pclk); #1;
        lock = 1'b0;
        cyc = 1;
        while (cyc < RST_CYC) begin
            @(posedge pclk); #1;
            cyc++;
        end
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_lines", 32'(lines), 32'd0);
        chk("arst_total", 32'(lines_total), 32'd0);
        chk("arst_go", 32'(game_over), 32'd0);
        chk("arst_rd", 32'(rd_data), 32'd0);
        @(negedge pclk);
        rst = 1'b0;
        model_reset();
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge pclk); #1;
            if (done) dones++;
        end
        chk("arst_no_done", 32'(dones), 32'd0);
        check_grid("arst", ROWS);

        // Randomized locks near the floor so rows fill and clear
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 4; k++) begin
                c[k] = 5'($urandom_range(0, 10));
                r[k] = 5'($urandom_range(15, 20));
            end
            do_lock(c, r, 1'b0, $sformatf("rnd%0d", n), meas);
            check_grid($sformatf("rnd%0d", n), ROWS);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
